cabin_zone_controller: RTL and testbench

Parametrised multi-zone cabin controller: debounces the flight phase, runs the cabin state machine and drives seatbelt and lock status. Manages independent lighting for NUM_ZONES cabin zones, with per-zone command hold-off and per-zone fault latching with acknowledge. Sits under the cabin top level as the successor to the single-zone cabin controller, adding zone scaling, fault acknowledge and lighting hold-off.

---
 rtl/cabin_pkg.sv | 67 ++++++
 rtl/cabin_phase_filter.sv | 56 +++++
 rtl/cabin_zone_controller.sv | 137 +++++++++++++
 tb/tb_cabin_zone_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cabin_pkg.sv
// Shared types, phase constants and small decode helpers for the multi-zone cabin controller.
package cabin_pkg;

  typedef enum logic [3:0] {
    ST_GROUND    = 4'd0,
    ST_TAXI      = 4'd1,
    ST_TAKEOFF   = 4'd2,
    ST_CLIMB     = 4'd3,
    ST_CRUISE    = 4'd4,
    ST_DESCENT   = 4'd5,
    ST_LANDING   = 4'd6,
    ST_EMERGENCY = 4'd8,
    ST_MAINT     = 4'd9
  } cabin_state_t;

  typedef enum logic [1:0] {
    LM_OFF    = 2'b00,
    LM_DIM    = 2'b01,
    LM_BRIGHT = 2'b10,
    LM_EMERG  = 2'b11
  } light_mode_t;

  localparam logic [2:0] PH_GROUND  = 3'd0;
  localparam logic [2:0] PH_TAXI    = 3'd1;
  localparam logic [2:0] PH_TAKEOFF = 3'd2;
  localparam logic [2:0] PH_CLIMB   = 3'd3;
  localparam logic [2:0] PH_CRUISE  = 3'd4;
  localparam logic [2:0] PH_DESCENT = 3'd5;
  localparam logic [2:0] PH_LANDING = 3'd6;
  localparam logic [2:0] PH_INVALID = 3'd7;

  function automatic cabin_state_t phase_to_state(input logic [2:0] ph);
    case (ph)
      PH_GROUND:  return ST_GROUND;
      PH_TAXI:    return ST_TAXI;
      PH_TAKEOFF: return ST_TAKEOFF;
      PH_CLIMB:   return ST_CLIMB;
      PH_CRUISE:  return ST_CRUISE;
      PH_DESCENT: return ST_DESCENT;
      PH_LANDING: return ST_LANDING;
      default:    return ST_GROUND;
    endcase
  endfunction

  function automatic light_mode_t next_light(input light_mode_t m);
    case (m)
      LM_OFF:  return LM_DIM;
      LM_DIM:  return LM_BRIGHT;
      default: return LM_OFF;
    endcase
  endfunction

  function automatic logic belt_for(input cabin_state_t s);
    case (s)
      ST_TAXI, ST_TAKEOFF, ST_CLIMB, ST_DESCENT, ST_LANDING, ST_EMERGENCY: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic lock_for(input cabin_state_t s);
    case (s)
      ST_TAKEOFF, ST_LANDING, ST_EMERGENCY, ST_MAINT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cabin_phase_filter.sv
// Flight-phase debouncer: adopts a raw phase once it has repeated for STABLE_CYCLES
// consecutive cycles; phase 7 is never adopted. commit pulses for one cycle after adoption.
module cabin_phase_filter
  import cabin_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] flight_phase,
  output logic [2:0] phase_stable,
  output logic       commit
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [2:0]    prev_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          same_s;
  logic          adopt_s;

  // Repeat counter, saturating at STABLE_CYCLES and restarting on change or on the invalid code.
  always_comb begin
    same_s = (flight_phase == prev_r) && (flight_phase != PH_INVALID);
    if (!same_s) begin
      cnt_next_s = {CW{1'b0}};
    end else if (cnt_r == CNT_MAX) begin
      cnt_next_s = cnt_r;
    end else begin
      cnt_next_s = cnt_r + CW'(1);
    end
    adopt_s = same_s && (cnt_next_s == CNT_MAX) && (flight_phase != phase_stable);
  end

  // Debounce registers and adopted phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r       <= 3'd0;
      cnt_r        <= {CW{1'b0}};
      phase_stable <= 3'd0;
      commit       <= 1'b0;
    end else begin
      prev_r <= flight_phase;
      cnt_r  <= cnt_next_s;
      commit <= adopt_s;
      if (adopt_s) begin
        phase_stable <= flight_phase;
      end else begin
        phase_stable <= phase_stable;
      end
    end
  end

endmodule

// File: rtl/cabin_zone_controller.sv
// Multi-zone cabin controller: phase-following state machine, per-zone lighting with hold-off,
// and sticky per-zone fault latching. Optional CABIN_FAULT_MASK_EN adds a per-zone fault_mask input.
module cabin_zone_controller
  import cabin_pkg::*;
#(
  parameter int NUM_ZONES     = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int LIGHT_HOLDOFF = 50
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             flight_phase,
  input  logic                   maintenance_mode,
  input  logic [NUM_ZONES-1:0]   light_cmd,
  input  logic [NUM_ZONES-1:0]   fault_in,
  input  logic                   fault_ack,
`ifdef CABIN_FAULT_MASK_EN
  input  logic [NUM_ZONES-1:0]   fault_mask,
`endif
  output logic                   seatbelt_on,
  output logic                   system_locked,
  output logic [2*NUM_ZONES-1:0] lighting_mode,
  output logic                   fault_alert,
  output logic [NUM_ZONES-1:0]   fault_zone,
  output logic [2:0]             phase_stable,
  output logic [3:0]             state_debug
);

  localparam int HW = (LIGHT_HOLDOFF > 0) ? $clog2(LIGHT_HOLDOFF + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(LIGHT_HOLDOFF);

  cabin_state_t           state_r;
  cabin_state_t           next_state_s;
  logic [HW-1:0]          holdoff_r [NUM_ZONES];
  logic [NUM_ZONES-1:0]   armed_s;
  logic                   commit_s;
  logic                   fault_hit_s;
  logic                   fault_clear_s;
  logic                   freeze_s;
  logic                   force_dim_s;
  logic                   accept_ok_s;

  cabin_phase_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_phase_filter (
    .clk         (clk),
    .reset       (reset),
    .flight_phase(flight_phase),
    .phase_stable(phase_stable),
    .commit      (commit_s)
  );

`ifdef CABIN_FAULT_MASK_EN
  assign armed_s = ~fault_mask;
`else
  assign armed_s = {NUM_ZONES{1'b1}};
`endif

  // Next state by priority fault > held emergency > maintenance > phase follow.
  always_comb begin
    fault_hit_s   = |(fault_in & armed_s);
    fault_clear_s = 1'b0;
    freeze_s      = 1'b0;
    force_dim_s   = 1'b0;
    if (fault_hit_s) begin
      next_state_s = ST_EMERGENCY;
    end else if (state_r == ST_EMERGENCY) begin
      if (fault_ack) begin
        fault_clear_s = 1'b1;
        next_state_s  = phase_to_state(phase_stable);
      end else begin
        next_state_s  = ST_EMERGENCY;
      end
    end else if (maintenance_mode) begin
      next_state_s = ST_MAINT;
      freeze_s     = 1'b1;
    end else begin
      next_state_s = phase_to_state(phase_stable);
      // The strobe marks the edge where the state moves to a freshly adopted phase.
      force_dim_s  = commit_s && (state_r != ST_MAINT) &&
                     ((next_state_s == ST_TAKEOFF) || (next_state_s == ST_LANDING));
    end
    accept_ok_s = !fault_hit_s && !maintenance_mode && !force_dim_s &&
                  ((state_r == ST_GROUND) || (state_r == ST_CRUISE));
  end

  // State, status outputs, fault latch, per-zone lighting and hold-off counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_GROUND;
      state_debug   <= 4'd0;
      seatbelt_on   <= 1'b0;
      system_locked <= 1'b0;
      fault_alert   <= 1'b0;
      fault_zone    <= {NUM_ZONES{1'b0}};
      lighting_mode <= {(2*NUM_ZONES){1'b0}};
      for (int z = 0; z < NUM_ZONES; z++) begin
        holdoff_r[z] <= {HW{1'b0}};
      end
    end else begin
      state_r       <= next_state_s;
      state_debug   <= next_state_s;
      seatbelt_on   <= belt_for(next_state_s);
      system_locked <= lock_for(next_state_s);
      fault_alert   <= (next_state_s == ST_EMERGENCY);

      if (fault_hit_s) begin
        fault_zone <= fault_zone | (fault_in & armed_s);
      end else if (fault_clear_s) begin
        fault_zone <= {NUM_ZONES{1'b0}};
      end else begin
        fault_zone <= fault_zone;
      end

      for (int z = 0; z < NUM_ZONES; z++) begin
        if (fault_hit_s) begin
          lighting_mode[2*z +: 2] <= LM_EMERG;
        end else if (fault_clear_s || force_dim_s) begin
          lighting_mode[2*z +: 2] <= LM_DIM;
        end else if (light_cmd[z] && accept_ok_s && (holdoff_r[z] == {HW{1'b0}})) begin
          lighting_mode[2*z +: 2] <= next_light(light_mode_t'(lighting_mode[2*z +: 2]));
        end else begin
          lighting_mode[2*z +: 2] <= lighting_mode[2*z +: 2];
        end

        if (light_cmd[z] && accept_ok_s && (holdoff_r[z] == {HW{1'b0}})) begin
          holdoff_r[z] <= HOLD_LOAD;
        end else if (freeze_s || (holdoff_r[z] == {HW{1'b0}})) begin
          holdoff_r[z] <= holdoff_r[z];
        end else begin
          holdoff_r[z] <= holdoff_r[z] - HW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cabin_zone_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic against a window/timestamp reference model.
module tb_cabin_zone_controller;

  localparam int NZ = 4;
  localparam int SC = 16;
  localparam int HO = 50;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      flight_phase;
  logic            maintenance_mode;
  logic [NZ-1:0]   light_cmd;
  logic [NZ-1:0]   fault_in;
  logic            fault_ack;
`ifdef CABIN_FAULT_MASK_EN
  logic [NZ-1:0]   fault_mask;
`endif
  logic            seatbelt_on;
  logic            system_locked;
  logic [2*NZ-1:0] lighting_mode;
  logic            fault_alert;
  logic [NZ-1:0]   fault_zone;
  logic [2:0]      phase_stable;
  logic [3:0]      state_debug;

  always #5 clk = ~clk;

  cabin_zone_controller #(
    .NUM_ZONES(NZ), .STABLE_CYCLES(SC), .LIGHT_HOLDOFF(HO)
  ) dut (
    .clk(clk), .reset(reset), .flight_phase(flight_phase),
    .maintenance_mode(maintenance_mode), .light_cmd(light_cmd),
    .fault_in(fault_in), .fault_ack(fault_ack),
`ifdef CABIN_FAULT_MASK_EN
    .fault_mask(fault_mask),
`endif
    .seatbelt_on(seatbelt_on), .system_locked(system_locked),
    .lighting_mode(lighting_mode), .fault_alert(fault_alert),
    .fault_zone(fault_zone), .phase_stable(phase_stable), .state_debug(state_debug)
  );

  int tests = 0;
  int errors = 0;

  // Reference model: phase adoption from a sample window, hold-off from timestamps of live cycles.
  int            m_st;
  int            m_stable;
  logic [NZ-1:0] m_fz;
  int            m_zone [NZ];
  int            hist [$];
  longint        live;
  longint        lacc [NZ];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2*NZ-1:0] model_light();
    logic [2*NZ-1:0] r;
    for (int z = 0; z < NZ; z++) r[2*z +: 2] = 2'(m_zone[z]);
    return r;
  endfunction

  task automatic model_edge();
    logic [NZ-1:0] armed, hits;
    int old_stable, ns;
    bit adopt, frozen;
    bit acc [NZ];
    if (reset) begin
      m_st = 0; m_stable = 0; m_fz = '0; live = 0;
      hist.delete(); hist.push_back(0);
      for (int z = 0; z < NZ; z++) begin m_zone[z] = 0; lacc[z] = -1000; end
      return;
    end
    hist.push_back(int'(flight_phase));
    while (hist.size() > SC + 1) void'(hist.pop_front());
    old_stable = m_stable;
    if (hist.size() == SC + 1 && hist[0] != 7 && hist[0] != m_stable) begin
      adopt = 1'b1;
      foreach (hist[i]) if (hist[i] != hist[0]) adopt = 1'b0;
      if (adopt) m_stable = hist[0];
    end
`ifdef CABIN_FAULT_MASK_EN
    armed = ~fault_mask;
`else
    armed = '1;
`endif
    hits = fault_in & armed;
    frozen = 1'b0;
    for (int z = 0; z < NZ; z++) acc[z] = 1'b0;
    if (hits != '0) begin
      m_st = 8; m_fz = m_fz | hits;
      for (int z = 0; z < NZ; z++) m_zone[z] = 3;
    end else if (m_st == 8) begin
      if (fault_ack) begin
        m_fz = '0; m_st = old_stable;
        for (int z = 0; z < NZ; z++) m_zone[z] = 1;
      end
    end else if (maintenance_mode) begin
      m_st = 9; frozen = 1'b1;
    end else begin
      ns = old_stable;
      if ((ns == 2 || ns == 6) && ns != m_st && m_st != 9) begin
        for (int z = 0; z < NZ; z++) m_zone[z] = 1;
      end else if (m_st == 0 || m_st == 4) begin
        for (int z = 0; z < NZ; z++) begin
          if (light_cmd[z] && (live - lacc[z] >= HO)) begin
            m_zone[z] = (m_zone[z] == 0) ? 1 : (m_zone[z] == 1) ? 2 : 0;
            acc[z] = 1'b1;
          end
        end
      end
      m_st = ns;
    end
    if (!frozen) live++;
    for (int z = 0; z < NZ; z++) if (acc[z]) lacc[z] = live;
  endtask

  task automatic compare_all();
    bit belt, lock;
    belt = (m_st == 1 || m_st == 2 || m_st == 3 || m_st == 5 || m_st == 6 || m_st == 8);
    lock = (m_st == 2 || m_st == 6 || m_st == 8 || m_st == 9);
    check("state_debug", 32'(state_debug), 32'(m_st));
    check("phase_stable", 32'(phase_stable), 32'(m_stable));
    check("seatbelt_on", 32'(seatbelt_on), 32'(belt));
    check("system_locked", 32'(system_locked), 32'(lock));
    check("fault_alert", 32'(fault_alert), 32'(m_st == 8));
    check("fault_zone", 32'(fault_zone), 32'(m_fz));
    check("lighting_mode", 32'(lighting_mode), 32'(model_light()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic pulse_light(input logic [NZ-1:0] m);
    light_cmd = m; tick(); light_cmd = '0;
  endtask

  int hold_left, fault_left;

  initial begin
    reset = 1'b1; flight_phase = 3'd0; maintenance_mode = 1'b0;
    light_cmd = '0; fault_in = '0; fault_ack = 1'b0;
`ifdef CABIN_FAULT_MASK_EN
    fault_mask = '0;
`endif
    repeat (2) tick();
    check("rst_state", 32'(state_debug), 32'd0);
    check("rst_light", 32'(lighting_mode), 32'h00);
    check("rst_flags", 32'({seatbelt_on, system_locked, fault_alert}), 32'd0);
    reset = 1'b0;

    for (int p = 0; p <= 4; p++) begin
      flight_phase = 3'(p);
      repeat (25) tick();
      check("phase_step_state", 32'(state_debug), 32'(p));
      if (p == 2) begin
        check("takeoff_lock", 32'({system_locked, seatbelt_on}), 32'b11);
        check("takeoff_light", 32'(lighting_mode), 32'h55);
      end
    end
    check("cruise_flags", 32'({system_locked, seatbelt_on}), 32'b00);

    pulse_light(4'b0010);
    check("cmd_accept", 32'(lighting_mode), 32'h59);
    repeat (9) tick();
    pulse_light(4'b0010);
    check("cmd_holdoff", 32'(lighting_mode), 32'h59);
    repeat (49) tick();
    pulse_light(4'b0010);
    check("cmd_after_holdoff", 32'(lighting_mode), 32'h51);

    flight_phase = 3'd5; repeat (8) tick();
    flight_phase = 3'd7; repeat (30) tick();
    flight_phase = 3'd4; tick();
    check("glitch_phase", 32'(phase_stable), 32'd4);
    check("glitch_state", 32'(state_debug), 32'd4);

    flight_phase = 3'd6; repeat (25) tick();
    check("landing_state", 32'(state_debug), 32'd6);
    check("landing_light", 32'(lighting_mode), 32'h55);
    fault_in = 4'b0100; tick();
    check("fault_state", 32'(state_debug), 32'd8);
    check("fault_alert_on", 32'(fault_alert), 32'd1);
    check("fault_zone_set", 32'(fault_zone), 32'b0100);
    check("fault_light", 32'(lighting_mode), 32'hFF);
    for (int i = 0; i < 9; i++) begin
      fault_ack = (i == 3); tick();
    end
    fault_ack = 1'b0;
    check("ack_ignored", 32'(state_debug), 32'd8);
    fault_in = '0; repeat (2) tick();
    check("fault_sticky", 32'(fault_zone), 32'b0100);
    fault_ack = 1'b1; tick(); fault_ack = 1'b0;
    check("ack_state", 32'(state_debug), 32'd6);
    check("ack_light", 32'(lighting_mode), 32'h55);
    check("ack_zone", 32'(fault_zone), 32'd0);

    maintenance_mode = 1'b1; flight_phase = 3'd4; tick();
    check("maint_state", 32'(state_debug), 32'd9);
    pulse_light(4'b0001);
    check("maint_light", 32'(lighting_mode), 32'h55);
    repeat (25) tick();
    maintenance_mode = 1'b0; tick();
    check("maint_exit", 32'(state_debug), 32'd4);

`ifdef CABIN_FAULT_MASK_EN
    fault_mask = 4'b0001; fault_in = 4'b0001; tick();
    check("mask_no_emerg", 32'(state_debug), 32'd4);
    check("mask_zone", 32'(fault_zone), 32'd0);
    fault_in = '0; fault_mask = '0; tick();
`endif

    hold_left = 0; fault_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold_left == 0) begin
        flight_phase = 3'($urandom_range(0, 7));
        hold_left = $urandom_range(1, 60);
      end else begin
        hold_left--;
      end
      light_cmd = ($urandom_range(0, 5) == 0) ? NZ'($urandom) : '0;
      if (fault_left == 0 && $urandom_range(0, 299) == 0) fault_left = $urandom_range(1, 10);
      if (fault_left > 0) begin
        fault_in = NZ'($urandom_range(1, (1 << NZ) - 1));
        fault_left--;
      end else begin
        fault_in = '0;
      end
      fault_ack = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 199) == 0) maintenance_mode = ~maintenance_mode;
      reset = ($urandom_range(0, 999) == 0);
`ifdef CABIN_FAULT_MASK_EN
      if ($urandom_range(0, 99) == 0) fault_mask = NZ'($urandom);
`endif
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
